// File: rtl/hamming_stream_decoder.sv
// Two-stage streaming SECDED decoder for extended Hamming (8,4) lanes with
// valid/ready on both sides and saturating corrected/uncorrectable counters.
module hamming_stream_decoder #(
    parameter int LANES   = 2,
    parameter int COUNT_W = 16
) (
    input  logic                 clock,
    input  logic                 n_reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   codeword,
    input  logic                 correct_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*LANES-1:0]   msg,
    output logic [LANES-1:0]     corrected,
    output logic [LANES-1:0]     uncorrectable,
    output logic                 errors,
    input  logic                 clear_counts,
    output logic [COUNT_W-1:0]   corr_count,
    output logic [COUNT_W-1:0]   uncorr_count
);

    logic                      w_s2_load;
    logic                      w_s1_load;
    logic [LANES-1:0][2:0]     w_syn;
    logic [LANES-1:0]          w_par;
    logic [LANES-1:0][3:0]     w_raw;

    logic                      r_s1_valid;
    logic [LANES-1:0][3:0]     r_s1_data;
    logic [LANES-1:0][2:0]     r_s1_syn;
    logic [LANES-1:0]          r_s1_par;
    logic                      r_s1_cen;

    logic [4*LANES-1:0]        w_msg;
    logic [LANES-1:0]          w_corr;
    logic [LANES-1:0]          w_unc;

    logic                      r_out_valid;
    logic [4*LANES-1:0]        r_msg;
    logic [LANES-1:0]          r_corrected;
    logic [LANES-1:0]          r_uncorr;

    logic [COUNT_W:0]          w_corr_pop;
    logic [COUNT_W:0]          w_unc_pop;
    logic [COUNT_W:0]          w_corr_sum;
    logic [COUNT_W:0]          w_unc_sum;
    logic [COUNT_W-1:0]        w_corr_next;
    logic [COUNT_W-1:0]        w_unc_next;
    logic [COUNT_W-1:0]        r_corr_count;
    logic [COUNT_W-1:0]        r_uncorr_count;

    assign w_s2_load = !r_out_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = w_s1_load;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_syn = '0;
        w_par = '0;
        w_raw = '0;
        for (int k = 0; k < LANES; k++) begin
            w_syn[k] = {codeword[8*k+3] ^ codeword[8*k+4] ^ codeword[8*k+5] ^ codeword[8*k+6],
                        codeword[8*k+1] ^ codeword[8*k+2] ^ codeword[8*k+5] ^ codeword[8*k+6],
                        codeword[8*k+0] ^ codeword[8*k+2] ^ codeword[8*k+4] ^ codeword[8*k+6]};
            w_par[k] = ^codeword[8*k +: 8];
            w_raw[k] = {codeword[8*k+6], codeword[8*k+5], codeword[8*k+4], codeword[8*k+2]};
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        // NOTE: non-blocking assignments so every stage samples pre-edge values.
        if (!n_reset) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
        end
    end

    // NOTE: S1 payload is left unreset; it is only consumed while r_s1_valid is set.
    always_ff @(posedge clock) begin
        if (w_s1_load && in_valid) begin
            r_s1_data <= w_raw;
            r_s1_syn  <= w_syn;
            r_s1_par  <= w_par;
            r_s1_cen  <= correct_en;
        end
    end

    // A single error on a parity position leaves the nibble untouched, so only
    // the four data positions (syndromes 3,5,6,7) ever need flipping.
    always_comb begin
        w_msg  = '0;
        w_corr = '0;
        w_unc  = '0;
        for (int k = 0; k < LANES; k++) begin
            w_corr[k] = r_s1_par[k];
            w_unc[k]  = !r_s1_par[k] && (r_s1_syn[k] != 3'd0);
            w_msg[4*k +: 4] = r_s1_data[k] ^
                ({r_s1_syn[k] == 3'd7, r_s1_syn[k] == 3'd6, r_s1_syn[k] == 3'd5, r_s1_syn[k] == 3'd3}
                 & {4{r_s1_par[k] && r_s1_cen}});
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_out_valid <= 1'b0;
            r_msg       <= '0;
            r_corrected <= '0;
            r_uncorr    <= '0;
        end else if (w_s2_load) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_msg       <= w_msg;
                r_corrected <= w_corr;
                r_uncorr    <= w_unc;
            end
        end
    end

    always_comb begin
        w_corr_pop = '0;
        w_unc_pop  = '0;
        for (int k = 0; k < LANES; k++) begin
            w_corr_pop = w_corr_pop + {{COUNT_W{1'b0}}, r_corrected[k]};
            w_unc_pop  = w_unc_pop  + {{COUNT_W{1'b0}}, r_uncorr[k]};
        end
        w_corr_sum  = {1'b0, r_corr_count}   + w_corr_pop;
        w_unc_sum   = {1'b0, r_uncorr_count} + w_unc_pop;
        w_corr_next = w_corr_sum[COUNT_W] ? {COUNT_W{1'b1}} : w_corr_sum[COUNT_W-1:0];
        w_unc_next  = w_unc_sum[COUNT_W]  ? {COUNT_W{1'b1}} : w_unc_sum[COUNT_W-1:0];
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_corr_count   <= '0;
            r_uncorr_count <= '0;
        end else if (clear_counts) begin
            r_corr_count   <= '0;
            r_uncorr_count <= '0;
        end else if (r_out_valid && out_ready) begin
            r_corr_count   <= w_corr_next;
            r_uncorr_count <= w_unc_next;
        end
    end

    assign out_valid     = r_out_valid;
    assign msg           = r_msg;
    assign corrected     = r_corrected;
    assign uncorrectable = r_uncorr;
    assign errors        = (|r_corrected) || (|r_uncorr);
    assign corr_count    = r_corr_count;
    assign uncorr_count  = r_uncorr_count;

endmodule

// File: tb/tb_hamming_stream_decoder.sv
// Bench for hamming_stream_decoder: nearest-codeword reference model, queue
// scoreboard checked every cycle, directed corner cases and random streaming.
`timescale 1ns/1ps
module tb_hamming_stream_decoder;

    typedef struct packed {
        logic [7:0] msg;
        logic [1:0] corr;
        logic [1:0] unc;
    } beat_t;

    logic        clock = 1'b0;
    logic        n_reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        correct_en = 1'b0;
    logic        out_ready = 1'b0;
    logic        clear_counts = 1'b0;
    logic [15:0] codeword = '0;

    logic        in_ready, out_valid, errors;
    logic [7:0]  msg;
    logic [1:0]  corrected, uncorrectable;
    logic [15:0] corr_count, uncorr_count;

    logic        in_ready2, out_valid2, errors2;
    logic [7:0]  msg2;
    logic [1:0]  corrected2, uncorrectable2;
    logic [1:0]  corr_count2, uncorr_count2;

    hamming_stream_decoder #(.LANES(2), .COUNT_W(16)) dut (
        .clock(clock), .n_reset(n_reset), .in_valid(in_valid), .in_ready(in_ready),
        .codeword(codeword), .correct_en(correct_en), .out_valid(out_valid),
        .out_ready(out_ready), .msg(msg), .corrected(corrected),
        .uncorrectable(uncorrectable), .errors(errors), .clear_counts(clear_counts),
        .corr_count(corr_count), .uncorr_count(uncorr_count)
    );

    hamming_stream_decoder #(.LANES(2), .COUNT_W(2)) dut_sat (
        .clock(clock), .n_reset(n_reset), .in_valid(in_valid), .in_ready(in_ready2),
        .codeword(codeword), .correct_en(correct_en), .out_valid(out_valid2),
        .out_ready(out_ready), .msg(msg2), .corrected(corrected2),
        .uncorrectable(uncorrectable2), .errors(errors2), .clear_counts(clear_counts),
        .corr_count(corr_count2), .uncorr_count(uncorr_count2)
    );

    always #5 clock = ~clock;

    int    n_cmp = 0;
    int    n_fail = 0;
    beat_t exp_q[$];
    int    m_corr = 0, m_unc = 0, m_corr2 = 0, m_unc2 = 0;
    int    stall_seen = 0;
    bit    rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] enc(input logic [3:0] d);
        logic p1, p2, p4;
        logic [6:0] c7;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        c7 = {d[3], d[2], d[1], p4, d[0], p2, p1};
        return {^c7, c7};
    endfunction

    // Decode by nearest valid codeword rather than by syndrome.
    function automatic beat_t model_beat(input logic [15:0] cw, input logic cen);
        beat_t      b;
        logic [7:0] c;
        int         hit;
        b = '0;
        for (int k = 0; k < 2; k++) begin
            c = cw[8*k +: 8];
            b.msg[4*k +: 4] = {c[6], c[5], c[4], c[2]};
            hit = -1;
            for (int d = 0; d < 16; d++)
                if ($countones(enc(4'(d)) ^ c) <= 1) hit = d;
            if (hit < 0) begin
                b.unc[k] = 1'b1;
            end else if (enc(4'(hit)) != c) begin
                b.corr[k] = 1'b1;
                if (cen) b.msg[4*k +: 4] = 4'(hit);
            end
        end
        return b;
    endfunction

    function automatic logic [15:0] rand_cw();
        logic [15:0] cw;
        logic [7:0]  c;
        int          nerr, b1, b2;
        for (int k = 0; k < 2; k++) begin
            c = enc(4'($urandom_range(0, 15)));
            nerr = $urandom_range(0, 2);
            b1 = $urandom_range(0, 7);
            b2 = (b1 + 1 + $urandom_range(0, 6)) % 8;
            if (nerr >= 1) c[b1] = ~c[b1];
            if (nerr == 2) c[b2] = ~c[b2];
            cw[8*k +: 8] = c;
        end
        return cw;
    endfunction

    function automatic int sat_add(input int a, input int b, input int mx);
        return (a + b > mx) ? mx : a + b;
    endfunction

    // Scoreboard: everything observed at the falling edge predicts the next rising edge.
    always @(negedge clock) begin
        beat_t e;
        if (!n_reset) begin
            exp_q.delete();
            m_corr = 0; m_unc = 0; m_corr2 = 0; m_unc2 = 0;
        end else begin
            check("corr_count",    corr_count,    m_corr);
            check("uncorr_count",  uncorr_count,  m_unc);
            check("corr_count2",   corr_count2,   m_corr2);
            check("uncorr_count2", uncorr_count2, m_unc2);
            if (!out_valid)  check("in_ready_when_empty",  in_ready,  1);
            if (!out_valid2) check("in_ready2_when_empty", in_ready2, 1);
            if (out_valid) begin
                check("beat_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q[0];
                    check("msg",           msg,           e.msg);
                    check("corrected",     corrected,     e.corr);
                    check("uncorrectable", uncorrectable, e.unc);
                    check("errors",        errors,        |{e.corr, e.unc});
                    check("sat_out_valid", out_valid2,    1);
                    check("sat_msg",       msg2,          e.msg);
                    check("sat_flags",     {corrected2, uncorrectable2, errors2},
                                           {e.corr, e.unc, |{e.corr, e.unc}});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        m_corr  = sat_add(m_corr,  $countones(e.corr), 65535);
                        m_unc   = sat_add(m_unc,   $countones(e.unc),  65535);
                        m_corr2 = sat_add(m_corr2, $countones(e.corr), 3);
                        m_unc2  = sat_add(m_unc2,  $countones(e.unc),  3);
                    end
                end
            end
            if (clear_counts) begin
                m_corr = 0; m_unc = 0; m_corr2 = 0; m_unc2 = 0;
            end
            if (in_valid && in_ready) exp_q.push_back(model_beat(codeword, correct_en));
            if (in_valid && !in_ready) stall_seen++;
        end
    end

    always @(posedge clock) begin
        if (rand_ready) begin
            #1;
            out_ready    = ($urandom_range(0, 3) != 0);
            clear_counts = ($urandom_range(0, 15) == 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send(input logic [15:0] cw, input logic cen);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; codeword = cw; correct_en = cen;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clock);
            if (in_ready) ok = 1'b1;
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        check("send_accepted", {31'b0, ok}, 1);
    endtask

    task automatic get_beat(output beat_t b);
        bit got;
        got = 1'b0;
        b = '0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            if (out_valid) begin
                got = 1'b1;
                b = '{msg: msg, corr: corrected, unc: uncorrectable};
            end
        end
        check("out_valid_seen", {31'b0, got}, 1);
        @(posedge clock); #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        beat_t b;

        // Pin the model to hand-decoded literals.
        b = model_beat(16'hD22D, 1'b1);
        check("model_clean", {b.msg, b.corr, b.unc}, {8'hA5, 2'b00, 2'b00});
        b = model_beat(16'hD23D, 1'b1);
        check("model_single_fix", {b.msg, b.corr, b.unc}, {8'hA5, 2'b01, 2'b00});
        b = model_beat(16'hD23D, 1'b0);
        check("model_single_raw", {b.msg, b.corr, b.unc}, {8'hA7, 2'b01, 2'b00});
        b = model_beat(16'hD12D, 1'b1);
        check("model_double", {b.msg[7:4], b.unc}, {4'hA, 2'b10});
        b = model_beat(16'h522D, 1'b1);
        check("model_p0_err", {b.msg, b.corr, b.unc}, {8'hA5, 2'b10, 2'b00});

        // Reset state.
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_msg", msg, 0);
        check("rst_flags", {corrected, uncorrectable, errors}, 0);
        check("rst_counts", {corr_count, uncorr_count}, 0);
        @(posedge clock); #1;
        n_reset = 1'b1;
        @(negedge clock);
        check("in_ready_after_reset", in_ready, 1);
        @(posedge clock); #1;

        // Two-cycle latency on a clean beat.
        out_ready = 1'b1;
        in_valid = 1'b1; codeword = 16'hD22D; correct_en = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("latency_one_cycle", out_valid, 0);
        @(posedge clock); #1;
        check("latency_two_cycles", out_valid, 1);
        check("clean_msg", msg, 8'hA5);
        check("clean_flags", {corrected, uncorrectable, errors}, 0);
        @(posedge clock); #1;

        // Directed single/double error cases.
        send(16'hD23D, 1'b1); get_beat(b);
        check("single_fix", {b.msg, b.corr, b.unc}, {8'hA5, 2'b01, 2'b00});
        send(16'hD23D, 1'b0); get_beat(b);
        check("single_detect_only", {b.msg, b.corr}, {8'hA7, 2'b01});
        send(16'hD12D, 1'b1); get_beat(b);
        check("double_err", {b.msg[7:4], b.unc, b.corr}, {4'hA, 2'b10, 2'b00});
        send(16'h522D, 1'b1); get_beat(b);
        check("p0_err", {b.msg, b.corr}, {8'hA5, 2'b10});
        cycles(3);
        @(negedge clock);
        check("corr_count_lit", corr_count, 3);
        check("uncorr_count_lit", uncorr_count, 1);
        @(posedge clock); #1;

        // Back-to-back stream with a three-cycle downstream stall.
        stall_seen = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) send(rand_cw(), 1'($urandom_range(0, 1)));
            end
            begin
                out_ready = 1'b1;
                cycles(3);
                out_ready = 1'b0;
                cycles(3);
                out_ready = 1'b1;
            end
        join
        cycles(8);
        check("in_ready_dropped", stall_seen != 0, 1);
        check("stream_drained", exp_q.size(), 0);

        // Saturation on the narrow counter.
        clear_counts = 1'b1; cycles(1); clear_counts = 1'b0;
        for (int i = 0; i < 5; i++) send(16'hD23D, 1'b1);
        cycles(4);
        @(negedge clock);
        check("corr_count_five", corr_count, 5);
        check("corr_count2_sat", corr_count2, 3);
        @(posedge clock); #1;

        // Clear wins over a flagged handshake.
        clear_counts = 1'b1;
        send(16'hD12D, 1'b1);
        cycles(4);
        @(negedge clock);
        check("clear_wins_uncorr", uncorr_count, 0);
        @(posedge clock); #1;
        clear_counts = 1'b0;

        // Asynchronous reset with two beats in flight.
        send(16'hD23D, 1'b1);
        cycles(3);
        out_ready = 1'b0;
        send(16'hD23D, 1'b1);
        send(16'hD12D, 1'b1);
        n_reset = 1'b0;
        #1;
        check("async_rst_out_valid", out_valid, 0);
        check("async_rst_counts", {corr_count, uncorr_count}, 0);
        @(negedge clock);
        @(posedge clock); #1;
        out_ready = 1'b1;
        n_reset = 1'b1;
        cycles(6);

        // Randomized streaming with random backpressure and clears.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(rand_cw(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
        end
        rand_ready = 1'b0;
        @(posedge clock); #2;
        out_ready = 1'b1;
        clear_counts = 1'b0;
        cycles(20);
        check("final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
